// File: rtl/coax_rx.sv
// Manchester coax receiver.
// Hunts for a quiesce/code-violation/sync preamble on the resynchronised line
// input. It then recovers 10-bit words (MSB first) plus an even-parity bit,
// with a sync bit between back-to-back words and an end bit closing the frame.
// Bit values are taken from mid-bit transitions, timed against the previous
// mid-bit edge.
module coax_rx #(
  parameter int CLOCKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  output logic       active,
  output logic [9:0] data,
  output logic       data_strobe,
  output logic       parity_error,
  output logic       error
);

  localparam int TW = $clog2(2 * CLOCKS_PER_BIT + 1);

  localparam logic [TW-1:0] T_Q14 = TW'(CLOCKS_PER_BIT / 4);
  localparam logic [TW-1:0] T_Q34 = TW'((3 * CLOCKS_PER_BIT) / 4);
  localparam logic [TW-1:0] T_Q54 = TW'((5 * CLOCKS_PER_BIT) / 4);
  localparam logic [TW-1:0] T_Q74 = TW'((7 * CLOCKS_PER_BIT) / 4);
  localparam logic [TW-1:0] T_TO  = TW'((5 * CLOCKS_PER_BIT) / 4 + 1);
  localparam logic [TW-1:0] T_MAX = TW'(2 * CLOCKS_PER_BIT);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    QUIESCE  = 4'd1,
    CV_LOW   = 4'd2,
    CV_HIGH  = 4'd3,
    SYNC     = 4'd4,
    DATA     = 4'd5,
    PARITY   = 4'd6,
    WORD_END = 4'd7,
    END      = 4'd8
  } state_t;

  // High when the received parity bit does not give even parity over the
  // sync bit (always 1), the 10 data bits and the parity bit itself.
  function automatic logic parity_bad(input logic [9:0] word, input logic pbit);
    return pbit != (1'b1 ^ (^word));
  endfunction

  state_t        state_r, state_nxt_s;
  logic          meta_r, sync_r, sync_d_r;
  logic [TW-1:0] t_r;
  logic [2:0]    qcnt_r, qcnt_nxt_s;
  logic [9:0]    shift_r;
  logic [3:0]    bcnt_r;
  logic [9:0]    data_r;
  logic          strobe_r, perr_r, error_r, active_r;

  logic edge_s, rise_s, level_s, mid_s, spacing_ok_s;
  logic t_clr_s, shift_clr_s, shift_en_s, bcnt_clr_s, bcnt_inc_s;
  logic load_s, err_s, act_set_s, act_clr_s;

  assign level_s      = sync_r;
  assign edge_s       = sync_r ^ sync_d_r;
  assign rise_s       = edge_s & sync_r;
  assign mid_s        = edge_s && (t_r >= T_Q34) && (t_r <= T_Q54);
  assign spacing_ok_s = (t_r >= T_Q34) && (t_r <= T_Q54);

  assign active       = active_r;
  assign data         = data_r;
  assign data_strobe  = strobe_r;
  assign parity_error = perr_r;
  assign error        = error_r;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic and per-cycle datapath controls.
  always_comb begin
    state_nxt_s = state_r;
    qcnt_nxt_s  = qcnt_r;
    t_clr_s     = 1'b0;
    shift_clr_s = 1'b0;
    shift_en_s  = 1'b0;
    bcnt_clr_s  = 1'b0;
    bcnt_inc_s  = 1'b0;
    load_s      = 1'b0;
    err_s       = 1'b0;
    act_set_s   = 1'b0;
    act_clr_s   = 1'b0;
    case (state_r)
      IDLE: begin
        // Rising edges one bit time apart are quiesce bits.
        if (rise_s) begin
          t_clr_s = 1'b1;
          if (spacing_ok_s) begin
            if (qcnt_r == 3'd4) begin
              qcnt_nxt_s  = 3'd0;
              state_nxt_s = QUIESCE;
            end else begin
              qcnt_nxt_s = qcnt_r + 3'd1;
            end
          end else begin
            qcnt_nxt_s = 3'd1;
          end
        end else begin
          qcnt_nxt_s = qcnt_r;
        end
      end
      QUIESCE: begin
        // Line is high; a falling edge starts a low-time measurement.
        if (edge_s) begin
          t_clr_s = 1'b1;
          if (!level_s) begin
            state_nxt_s = CV_LOW;
          end else begin
            state_nxt_s = IDLE;
          end
        end else if (t_r > T_Q74) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = QUIESCE;
        end
      end
      CV_LOW: begin
        // Short low is another quiesce bit, a 1.5-bit low is the violation.
        if (edge_s) begin
          t_clr_s = 1'b1;
          if (t_r <= T_Q34) begin
            state_nxt_s = QUIESCE;
          end else if ((t_r >= T_Q54) && (t_r <= T_Q74)) begin
            state_nxt_s = CV_HIGH;
          end else begin
            state_nxt_s = IDLE;
          end
        end else if (t_r > T_Q74) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = CV_LOW;
        end
      end
      CV_HIGH: begin
        if (edge_s) begin
          t_clr_s = 1'b1;
          if (!level_s && (t_r >= T_Q54) && (t_r <= T_Q74)) begin
            state_nxt_s = SYNC;
          end else begin
            state_nxt_s = IDLE;
          end
        end else if (t_r > T_Q74) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = CV_HIGH;
        end
      end
      SYNC: begin
        // Mid-bit rise of the sync bit becomes the first timing reference.
        if (edge_s) begin
          t_clr_s = 1'b1;
          if (level_s && (t_r >= T_Q14) && (t_r <= T_Q34)) begin
            act_set_s   = 1'b1;
            shift_clr_s = 1'b1;
            bcnt_clr_s  = 1'b1;
            state_nxt_s = DATA;
          end else begin
            state_nxt_s = IDLE;
          end
        end else if (t_r > T_Q34) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = SYNC;
        end
      end
      DATA: begin
        if (mid_s) begin
          t_clr_s    = 1'b1;
          shift_en_s = 1'b1;
          if (bcnt_r == 4'd9) begin
            state_nxt_s = PARITY;
          end else begin
            bcnt_inc_s = 1'b1;
          end
        end else if (t_r >= T_TO) begin
          err_s       = 1'b1;
          act_clr_s   = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DATA;
        end
      end
      PARITY: begin
        if (mid_s) begin
          t_clr_s     = 1'b1;
          load_s      = 1'b1;
          state_nxt_s = WORD_END;
        end else if (t_r >= T_TO) begin
          err_s       = 1'b1;
          act_clr_s   = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = PARITY;
        end
      end
      WORD_END: begin
        // A 1 here is the sync bit of a following word, a 0 is the end bit.
        if (mid_s) begin
          t_clr_s = 1'b1;
          if (level_s) begin
            shift_clr_s = 1'b1;
            bcnt_clr_s  = 1'b1;
            state_nxt_s = DATA;
          end else begin
            state_nxt_s = END;
          end
        end else if (t_r >= T_TO) begin
          err_s       = 1'b1;
          act_clr_s   = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WORD_END;
        end
      end
      END: begin
        // Silence after the end bit closes the frame; more bits are an error.
        if (mid_s) begin
          err_s       = 1'b1;
          act_clr_s   = 1'b1;
          state_nxt_s = IDLE;
        end else if (t_r >= T_TO) begin
          act_clr_s   = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = END;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Line synchroniser, edge timer, shift register and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_r   <= 1'b1;
      sync_r   <= 1'b1;
      sync_d_r <= 1'b1;
      t_r      <= '0;
      qcnt_r   <= 3'd0;
      shift_r  <= 10'd0;
      bcnt_r   <= 4'd0;
      data_r   <= 10'd0;
      strobe_r <= 1'b0;
      perr_r   <= 1'b0;
      error_r  <= 1'b0;
      active_r <= 1'b0;
    end else begin
      meta_r   <= rx;
      sync_r   <= meta_r;
      sync_d_r <= sync_r;
      if (t_clr_s) begin
        t_r <= '0;
      end else if (t_r == T_MAX) begin
        t_r <= t_r;
      end else begin
        t_r <= t_r + TW'(1);
      end
      qcnt_r <= qcnt_nxt_s;
      if (shift_clr_s) begin
        shift_r <= 10'd0;
      end else if (shift_en_s) begin
        shift_r <= {shift_r[8:0], level_s};
      end else begin
        shift_r <= shift_r;
      end
      if (bcnt_clr_s) begin
        bcnt_r <= 4'd0;
      end else if (bcnt_inc_s) begin
        bcnt_r <= bcnt_r + 4'd1;
      end else begin
        bcnt_r <= bcnt_r;
      end
      if (load_s) begin
        data_r <= shift_r;
        perr_r <= parity_bad(shift_r, level_s);
      end else begin
        data_r <= data_r;
        perr_r <= perr_r;
      end
      strobe_r <= load_s;
      error_r  <= err_s;
      if (act_set_s) begin
        active_r <= 1'b1;
      end else if (act_clr_s) begin
        active_r <= 1'b0;
      end else begin
        active_r <= active_r;
      end
    end
  end

endmodule

// File: tb/tb_coax_rx.sv
// Directed bench for coax_rx: a table of single-word frames plus hand-built
// sequences for back-to-back words, a late mid-bit edge and a mid-frame reset.
module tb_coax_rx;

  localparam int N = 8;
  localparam int H = N / 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       rx = 1'b0;
  logic       active;
  logic [9:0] data;
  logic       data_strobe;
  logic       parity_error;
  logic       error;

  int checks = 0;
  int errors = 0;

  int         strobe_cnt = 0;
  int         error_cnt = 0;
  int         both_cnt = 0;
  int         act_gap_cnt = 0;
  logic       watch = 1'b0;
  logic       mon_perr = 1'b0;
  logic [9:0] strobe_q[$];

  coax_rx #(.CLOCKS_PER_BIT(N)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx           (rx),
    .active       (active),
    .data         (data),
    .data_strobe  (data_strobe),
    .parity_error (parity_error),
    .error        (error)
  );

  always #5 clk = ~clk;

  // Output monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (data_strobe) begin
      strobe_cnt = strobe_cnt + 1;
      mon_perr   = parity_error;
      strobe_q.push_back(data);
    end
    if (error) error_cnt = error_cnt + 1;
    if (data_strobe && error) both_cnt = both_cnt + 1;
    if (watch && !active) act_gap_cnt = act_gap_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic hold(input logic lvl, input int cycles);
    rx = lvl;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    hold(~b, H);
    hold(b, H);
  endtask

  task automatic send_preamble(input int q);
    for (int i = 0; i < q; i++) send_bit(1'b1);
    hold(1'b0, 3 * H);
    hold(1'b1, 3 * H);
    send_bit(1'b1);
  endtask

  task automatic send_data(input logic [9:0] w);
    for (int i = 9; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic send_frame(input int q, input logic [9:0] w, input logic p);
    send_preamble(q);
    send_data(w);
    send_bit(p);
    send_bit(1'b0);
    hold(1'b0, 40);
  endtask

  typedef struct {
    int         q;
    logic [9:0] w;
    logic       p;
    int         exp_strb;
    logic [9:0] exp_data;
    logic       exp_perr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int s0, e0;
    vecs[0] = '{6, 10'h005, 1'b1, 1, 10'h005, 1'b0};
    vecs[1] = '{6, 10'h005, 1'b0, 1, 10'h005, 1'b1};
    vecs[2] = '{4, 10'h005, 1'b1, 0, 10'h005, 1'b0};
    vecs[3] = '{5, 10'h000, 1'b1, 1, 10'h000, 1'b0};
    vecs[4] = '{6, 10'h2A5, 1'b0, 1, 10'h2A5, 1'b0};
    vecs[5] = '{6, 10'h3FF, 1'b0, 1, 10'h3FF, 1'b1};

    // Reset state.
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_active", {31'd0, active}, 32'd0);
    check("rst_data", {22'd0, data}, 32'd0);
    check("rst_strobe", {31'd0, data_strobe}, 32'd0);
    check("rst_perr", {31'd0, parity_error}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    reset_n = 1'b1;
    hold(1'b0, 40);

    // Single-word frames.
    for (int i = 0; i < 6; i++) begin
      s0 = strobe_cnt;
      e0 = error_cnt;
      send_frame(vecs[i].q, vecs[i].w, vecs[i].p);
      check($sformatf("v%0d_strobes", i), strobe_cnt - s0, vecs[i].exp_strb);
      check($sformatf("v%0d_errors", i), error_cnt - e0, 32'd0);
      check($sformatf("v%0d_data", i), {22'd0, data}, {22'd0, vecs[i].exp_data});
      check($sformatf("v%0d_active", i), {31'd0, active}, 32'd0);
      if (vecs[i].exp_strb != 0) begin
        check($sformatf("v%0d_perr", i), {31'd0, mon_perr}, {31'd0, vecs[i].exp_perr});
      end
    end

    // Back-to-back words 0x3FF then 0x155 with a sync bit between them.
    strobe_q.delete();
    s0 = strobe_cnt;
    e0 = error_cnt;
    act_gap_cnt = 0;
    send_preamble(6);
    send_bit(1'b1);
    watch = 1'b1;
    for (int i = 8; i >= 0; i--) send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    send_data(10'h155);
    send_bit(1'b0);
    watch = 1'b0;
    send_bit(1'b0);
    hold(1'b0, 40);
    check("b2b_strobes", strobe_cnt - s0, 32'd2);
    check("b2b_errors", error_cnt - e0, 32'd0);
    check("b2b_active_gap", act_gap_cnt, 32'd0);
    check("b2b_word0", (strobe_q.size() > 0) ? {22'd0, strobe_q[0]} : 32'hFFFF, 32'h3FF);
    check("b2b_word1", (strobe_q.size() > 1) ? {22'd0, strobe_q[1]} : 32'hFFFF, 32'h155);
    check("b2b_active_end", {31'd0, active}, 32'd0);

    // Sixth data bit's mid-bit edge arrives late at T = 5N/4 + 1.
    s0 = strobe_cnt;
    e0 = error_cnt;
    send_preamble(6);
    for (int i = 9; i >= 0; i--) begin
      if (i == 4) begin
        hold(1'b1, H + 3);
        hold(1'b0, H - 3);
      end else begin
        send_bit(10'h005 >> i);
      end
    end
    send_bit(1'b1);
    send_bit(1'b0);
    hold(1'b0, 40);
    check("late_errors", error_cnt - e0, 32'd1);
    check("late_strobes", strobe_cnt - s0, 32'd0);
    check("late_active", {31'd0, active}, 32'd0);

    s0 = strobe_cnt;
    send_frame(6, 10'h005, 1'b1);
    check("recov_strobes", strobe_cnt - s0, 32'd1);
    check("recov_data", {22'd0, data}, 32'h005);
    check("recov_perr", {31'd0, mon_perr}, 32'd0);

    // Reset pulsed during the fourth data bit.
    send_preamble(6);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    hold(1'b1, 2);
    check("mid_active_before", {31'd0, active}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_active", {31'd0, active}, 32'd0);
    check("mid_rst_data", {22'd0, data}, 32'd0);
    check("mid_rst_strobe", {31'd0, data_strobe}, 32'd0);
    check("mid_rst_perr", {31'd0, parity_error}, 32'd0);
    check("mid_rst_error", {31'd0, error}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    hold(1'b0, 40);
    s0 = strobe_cnt;
    e0 = error_cnt;
    send_frame(6, 10'h2A5, 1'b0);
    check("post_rst_strobes", strobe_cnt - s0, 32'd1);
    check("post_rst_errors", error_cnt - e0, 32'd0);
    check("post_rst_data", {22'd0, data}, 32'h2A5);
    check("post_rst_perr", {31'd0, mon_perr}, 32'd0);

    check("strobe_error_overlap", both_cnt, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/coax_rx.md
COAX_RX -- requirements
Module: coax_rx

Interface
REQ-001 Parameter: CLOCKS_PER_BIT, default 8, number of clk cycles per coax bit time (N below); SHALL be even and >= 8.
REQ-002 Port: clk  input  1  sole clock; all state SHALL be updated on its rising edge.
REQ-003 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: rx  input  1  asynchronous Manchester line input, same polarity as the transmitter's tx.
REQ-005 Port: active  output  1  high while a frame is being received.
REQ-006 Port: data  output  10  last received word, MSB first on the line; held between strobes.
REQ-007 Port: data_strobe  output  1  one-cycle pulse, data and parity_error valid.
REQ-008 Port: parity_error  output  1  qualified by data_strobe; high if the word failed parity.
REQ-009 Port: error  output  1  one-cycle pulse on framing/timing failure inside a frame.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer; an edge is detected when the synchronized value differs from its 1-cycle-delayed copy.
REQ-011 A saturating counter T SHALL count clk cycles since the last reference edge; width SHALL hold 2N without wrap.
REQ-012 States: IDLE, QUIESCE, CV_LOW, CV_HIGH, SYNC, DATA, PARITY, WORD_END, END.
REQ-013 IDLE: rising edges spaced T in [3N/4, 5N/4] SHALL increment a quiesce count; any other spacing SHALL set count to 1; count reaching 5 SHALL enter QUIESCE.
REQ-014 QUIESCE: the falling edge SHALL start a low-time measurement; low lasting <= 3N/4 stays in QUIESCE; low in [5N/4, 7N/4] SHALL enter CV_HIGH; anything else SHALL return to IDLE.
REQ-015 CV_HIGH: high time in [5N/4, 7N/4] then a falling edge SHALL enter SYNC; otherwise return to IDLE.
REQ-016 SYNC: a rising edge at T in [N/4, 3N/4] after that falling edge SHALL become the timing reference (T:=0), set active=1, clear the 10-bit shift register and bit count, enter DATA; else IDLE.
REQ-017 Pre-SYNC failures SHALL NOT pulse error.
REQ-018 DATA/PARITY/WORD_END/END: an edge with T < 3N/4 is a bit-boundary edge and SHALL be ignored; an edge with T in [3N/4, 5N/4] is a mid-bit edge, bit value = new line level, T:=0.
REQ-019 DATA: each mid-bit bit SHALL shift in at the LSB; after the 10th bit enter PARITY.
REQ-020 PARITY: on its mid-bit edge, data SHALL load the shift register, parity_error SHALL equal (parity bit != 1 XOR reduction-XOR of the 10 bits) (even parity including sync bit), data_strobe SHALL pulse the next cycle; enter WORD_END.
REQ-021 WORD_END: mid-bit value 1 is a new sync bit -> clear bit count, enter DATA; value 0 is the end bit -> enter END.
REQ-022 END: T reaching 5N/4+1 with no mid-bit edge SHALL enter IDLE, active=0, no error.
REQ-023 DATA/PARITY/WORD_END: T reaching 5N/4+1 with no mid-bit edge SHALL pulse error, drop active, enter IDLE; no data_strobe for the partial word.
REQ-024 END: a mid-bit edge SHALL pulse error and enter IDLE.
REQ-025 Back-to-back words SHALL each produce one data_strobe; active SHALL stay high between them.
REQ-026 data_strobe and error SHALL never be high in the same cycle.

Reset
REQ-027 reset_n low SHALL immediately force: state IDLE, counters 0, synchronizer flops 1, active 0, data 0, data_strobe 0, parity_error 0, error 0.
REQ-028 Reset mid-frame SHALL discard the partial word; after release a full quiesce/CV/sync preamble is required.

Verification
REQ-029 N=8, 6 quiesce bits, CV, sync, data 0x005, parity 1, end bit -> one data_strobe, data=0x005, parity_error=0, active low after end timeout.
REQ-030 Same frame with parity bit 0 -> data=0x005, parity_error=1, error=0.
REQ-031 Words 0x3FF, 0x155 back-to-back (sync between, no preamble) -> two strobes in order, active continuously high.
REQ-032 Only 4 quiesce bits before CV -> no strobe, no error, active stays 0.
REQ-033 Mid-bit edge of data bit 5 delayed to T=11 -> single error pulse, active 0, no strobe; next full frame received correctly.
REQ-034 reset_n pulsed low during data bit 3 -> all outputs 0 at once; subsequent full frame received correctly.
